// File: rtl/game_ctrl.sv
// Tic-tac-toe game controller: move legality, win/draw detection and a
// vblank-synchronised copy of the board for the display pipeline.
module game_ctrl (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       move_valid,
  input  logic [3:0] move_idx,
  input  logic       new_game,
  output logic       move_ack,
  output logic       move_err,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [8:0] sq_x,
  output logic [8:0] sq_o
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    EVAL  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     state_q;
  logic [8:0] brd_x_q;
  logic [8:0] brd_o_q;
  logic [3:0] mv_cnt_q;
  logic [3:0] idx_q;
  logic       turn_q;
  logic [1:0] winner_q;
  logic       ack_q;
  logic       err_q;
  logic       over_q;
  logic       vblnk_q;
  logic [8:0] sq_x_q;
  logic [8:0] sq_o_q;

  logic [8:0] cur_brd_s;
  logic [8:0] mark_s;
  logic       bad_move_s;
  logic       vblnk_rise_s;

  function automatic logic has_line(input logic [8:0] b);
    has_line = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) |
               (b[6] & b[7] & b[8]) | (b[0] & b[3] & b[6]) |
               (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  always_comb begin
    cur_brd_s    = turn_q ? brd_o_q : brd_x_q;
    mark_s       = 9'd1 << idx_q;
    vblnk_rise_s = vblnk_in & ~vblnk_q;
    if (idx_q > 4'd8) begin
      bad_move_s = 1'b1;
    end else begin
      bad_move_s = |((brd_x_q | brd_o_q) & mark_s);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= PLAY;
      brd_x_q  <= 9'd0;
      brd_o_q  <= 9'd0;
      mv_cnt_q <= 4'd0;
      idx_q    <= 4'd0;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (new_game) begin
        // Restart wins over any move in flight; its ack/err is dropped.
        state_q  <= PLAY;
        brd_x_q  <= 9'd0;
        brd_o_q  <= 9'd0;
        mv_cnt_q <= 4'd0;
        turn_q   <= 1'b0;
        winner_q <= 2'b00;
        over_q   <= 1'b0;
      end else begin
        case (state_q)
          PLAY: begin
            if (move_valid) begin
              idx_q   <= move_idx;
              state_q <= CHECK;
            end
          end
          CHECK: begin
            if (bad_move_s) begin
              err_q   <= 1'b1;
              state_q <= PLAY;
            end else begin
              if (turn_q) begin
                brd_o_q <= brd_o_q | mark_s;
              end else begin
                brd_x_q <= brd_x_q | mark_s;
              end
              mv_cnt_q <= mv_cnt_q + 4'd1;
              ack_q    <= 1'b1;
              state_q  <= EVAL;
            end
          end
          EVAL: begin
            // Board already holds the new mark; a win on move 9 beats a draw.
            if (has_line(cur_brd_s)) begin
              winner_q <= turn_q ? 2'b10 : 2'b01;
              over_q   <= 1'b1;
              state_q  <= OVER;
            end else if (mv_cnt_q == 4'd9) begin
              winner_q <= 2'b11;
              over_q   <= 1'b1;
              state_q  <= OVER;
            end else begin
              turn_q  <= ~turn_q;
              state_q <= PLAY;
            end
          end
          OVER: begin
            if (move_valid) begin
              err_q <= 1'b1;
            end
          end
          default: begin
            state_q <= PLAY;
          end
        endcase
      end
    end
  end

  // The copy samples the board before any write landing on the same edge.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      sq_x_q  <= 9'd0;
      sq_o_q  <= 9'd0;
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_rise_s) begin
        sq_x_q <= brd_x_q;
        sq_o_q <= brd_o_q;
      end
    end
  end

  assign move_ack  = ack_q;
  assign move_err  = err_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign sq_x      = sq_x_q;
  assign sq_o      = sq_o_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a square-array reference model predicts
// each move outcome; a negedge monitor matches DUT pulses against the queue.
module tb_game_ctrl;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk_in = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_idx = 4'd0;
  logic       new_game = 1'b0;
  logic       move_ack;
  logic       move_err;
  logic       turn;
  logic [1:0] winner;
  logic       game_over;
  logic [8:0] sq_x;
  logic [8:0] sq_o;

  game_ctrl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .move_valid(move_valid),
    .move_idx(move_idx), .new_game(new_game), .move_ack(move_ack),
    .move_err(move_err), .turn(turn), .winner(winner), .game_over(game_over),
    .sq_x(sq_x), .sq_o(sq_o)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    bit          ack;
    int unsigned cyc;
    bit          turn;
    logic [1:0]  win;
    bit          over;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: 0 empty, 1 X, 2 O
  int         brd[9];
  bit         mturn;
  logic [1:0] mwin;
  bit         mover;
  int         mcnt;
  logic [8:0] disp_x = 9'd0;
  logic [8:0] disp_o = 9'd0;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] mask(input int p);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) m[i] = (brd[i] == p);
    return m;
  endfunction

  function automatic bit has_win(input int p);
    for (int l = 0; l < 8; l++)
      if (brd[lines[l][0]] == p && brd[lines[l][1]] == p && brd[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) brd[i] = 0;
    mturn = 1'b0; mwin = 2'b00; mover = 1'b0; mcnt = 0;
  endtask

  task automatic model_move(input int idx, input int unsigned k);
    exp_t e;
    if (mover) begin
      e.ack = 1'b0; e.cyc = k + 1;
    end else if (idx > 8) begin
      e.ack = 1'b0; e.cyc = k + 2;
    end else if (brd[idx] != 0) begin
      e.ack = 1'b0; e.cyc = k + 2;
    end else begin
      e.ack = 1'b1; e.cyc = k + 2;
      brd[idx] = mturn ? 2 : 1;
      mcnt++;
      if (has_win(brd[idx])) begin
        mwin = mturn ? 2'b10 : 2'b01; mover = 1'b1;
      end else if (mcnt == 9) begin
        mwin = 2'b11; mover = 1'b1;
      end else begin
        mturn = ~mturn;
      end
    end
    e.turn = mturn; e.win = mwin; e.over = mover;
    expq.push_back(e);
  endtask

  task automatic do_move(input int idx);
    @(posedge pclk); #1;
    move_valid = 1'b1;
    move_idx = 4'(idx);
    model_move(idx, cyc);
    @(posedge pclk); #1;
    move_valid = 1'b0;
    @(posedge pclk);
  endtask

  task automatic do_new(input bit with_move, input int idx);
    @(posedge pclk); #1;
    new_game = 1'b1;
    move_valid = with_move;
    move_idx = 4'(idx);
    @(posedge pclk); #1;
    new_game = 1'b0;
    move_valid = 1'b0;
    model_clear();
    check("new_turn", 32'(turn), 32'(mturn));
    check("new_winner", 32'(winner), 32'(mwin));
    check("new_over", 32'(game_over), 32'(mover));
    check("new_disp_hold_x", 32'(sq_x), 32'(disp_x));
  endtask

  task automatic vb_pulse(input string name);
    @(posedge pclk); #1;
    vblnk_in = 1'b1;
    disp_x = mask(1);
    disp_o = mask(2);
    @(posedge pclk); #1;
    vblnk_in = 1'b0;
    check({name, "_sqx"}, 32'(sq_x), 32'(disp_x));
    check({name, "_sqo"}, 32'(sq_o), 32'(disp_o));
  endtask

  // Monitor: every ack/err pulse must match the oldest expectation
  exp_t        chk_e;
  bit          chk_pend = 1'b0;
  int unsigned chk_cyc = 0;
  always @(negedge pclk) begin
    if (chk_pend && cyc == chk_cyc) begin
      chk_pend = 1'b0;
      check("post_turn", 32'(turn), 32'(chk_e.turn));
      check("post_winner", 32'(winner), 32'(chk_e.win));
      check("post_over", 32'(game_over), 32'(chk_e.over));
    end
    if (move_ack && move_err) check("ack_err_both", 32'(1), 32'(0));
    if (move_ack || move_err) begin
      if (expq.size() == 0) begin
        check("unexpected_pulse", 32'({move_ack, move_err}), 32'(0));
      end else begin
        chk_e = expq.pop_front();
        check("pulse_kind_ack", 32'(move_ack), 32'(chk_e.ack));
        check("pulse_cycle", cyc, chk_e.cyc);
        chk_pend = 1'b1;
        chk_cyc = cyc + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pre_x;
    logic [8:0] pre_o;
    int         guard;
    model_clear();
    // Reset overrides simultaneous new_game and move_valid
    move_valid = 1'b1; move_idx = 4'd0; new_game = 1'b1; vblnk_in = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_ack", 32'(move_ack), 32'(0));
    check("rst_err", 32'(move_err), 32'(0));
    check("rst_turn", 32'(turn), 32'(0));
    check("rst_winner", 32'(winner), 32'(0));
    check("rst_over", 32'(game_over), 32'(0));
    check("rst_sqx", 32'(sq_x), 32'(0));
    check("rst_sqo", 32'(sq_o), 32'(0));
    rst = 1'b0; move_valid = 1'b0; new_game = 1'b0; vblnk_in = 1'b0;

    // Centre move, then its appearance on the display
    do_move(4);
    vb_pulse("centre");
    check("centre_sqx_const", 32'(sq_x), 32'h010);
    // Occupied and out-of-range squares
    do_move(4);
    do_move(12);

    // X wins on the top row, then a move in OVER is refused
    do_new(1'b0, 0);
    do_move(0); do_move(3); do_move(1); do_move(4); do_move(2);
    do_move(5);
    check("xwin_model", 32'(mwin), 32'(2'b01));

    // Full board, no line
    do_new(1'b0, 0);
    do_move(0); do_move(1); do_move(2); do_move(4); do_move(3);
    do_move(5); do_move(7); do_move(6); do_move(8);
    check("draw_model", 32'(mwin), 32'(2'b11));
    vb_pulse("draw");

    // Display frozen while vblank stays high
    do_new(1'b0, 0);
    @(posedge pclk); #1;
    vblnk_in = 1'b1;
    disp_x = mask(1); disp_o = mask(2);
    do_move(6);
    #1;
    check("hold_sqx", 32'(sq_x), 32'(disp_x));
    check("hold_sqo", 32'(sq_o), 32'(disp_o));
    @(posedge pclk); #1;
    vblnk_in = 1'b0;
    vb_pulse("rehigh");

    // Board write and vblank edge on the same edge: old board is shown
    @(posedge pclk); #1;
    move_valid = 1'b1; move_idx = 4'd2;
    pre_x = mask(1); pre_o = mask(2);
    model_move(2, cyc);
    @(posedge pclk); #1;
    move_valid = 1'b0; vblnk_in = 1'b1;
    @(posedge pclk); #1;
    vblnk_in = 1'b0;
    check("same_edge_sqx", 32'(sq_x), 32'(pre_x));
    check("same_edge_sqo", 32'(sq_o), 32'(pre_o));
    disp_x = pre_x; disp_o = pre_o;
    vb_pulse("next_frame");

    // Restart coincident with a move: move discarded, display clears at vblank
    do_new(1'b1, 0);
    vb_pulse("cleared");

    // Restart while a move sits in CHECK: no pulse
    do_move(1);
    @(posedge pclk); #1;
    move_valid = 1'b1; move_idx = 4'd5;
    @(posedge pclk); #1;
    move_valid = 1'b0; new_game = 1'b1;
    @(posedge pclk); #1;
    new_game = 1'b0;
    model_clear();
    check("ng_check_turn", 32'(turn), 32'(0));
    vb_pulse("ng_check");

    // Reset while a move sits in CHECK
    do_move(8);
    vb_pulse("pre_rst");
    @(posedge pclk); #1;
    move_valid = 1'b1; move_idx = 4'd0;
    @(posedge pclk); #1;
    move_valid = 1'b0; rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    model_clear();
    disp_x = 9'd0; disp_o = 9'd0;
    check("midrst_sqx", 32'(sq_x), 32'(0));
    check("midrst_turn", 32'(turn), 32'(0));
    check("midrst_over", 32'(game_over), 32'(0));

    // Random games against the model
    repeat (8) begin
      guard = 0;
      while (!mover && guard < 40) begin
        do_move($urandom_range(0, 10));
        if ($urandom_range(0, 3) == 0) vb_pulse("rand");
        guard++;
      end
      do_move($urandom_range(0, 15));
      do_new(1'b0, 0);
    end

    repeat (6) @(posedge pclk);
    #1;
    check("queue_drained", 32'(expq.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The module SHALL have these ports (clock and reset first):
- pclk  in  1  pixel clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- vblnk_in  in  1  vertical blanking from the timing chain
- move_valid  in  1  one-cycle move request strobe
- move_idx  in  4  requested square 0..8, row-major, 0 = top-left
- new_game  in  1  one-cycle restart strobe
- move_ack  out  1  one-cycle pulse: move accepted
- move_err  out  1  one-cycle pulse: move rejected
- turn  out  1  player to move; 0 = X, 1 = O
- winner  out  2  00 none, 01 X, 10 O, 11 draw
- game_over  out  1  high while in OVER
- sq_x  out  9  displayed X marks, bit n = square n, feeds the draw stages
- sq_o  out  9  displayed O marks, bit n = square n

Function
REQ-002 The module SHALL hold internal board registers brd_x[8:0] and brd_o[8:0], plus a 4-bit move counter mv_cnt ranging 0..9.
REQ-003 The FSM SHALL have the states PLAY, CHECK, EVAL and OVER.
REQ-004 PLAY: when move_valid=1, the module SHALL latch move_idx into idx_r and go to CHECK on the next cycle; otherwise it SHALL stay in PLAY.
REQ-005 CHECK, reject path: if idx_r>8, or brd_x[idx_r] or brd_o[idx_r] is set, the module SHALL pulse move_err for one cycle and return to PLAY with the board unchanged.
REQ-006 CHECK, accept path: otherwise the module SHALL set brd_x[idx_r] (turn=0) or brd_o[idx_r] (turn=1), increment mv_cnt, pulse move_ack for one cycle, and go to EVAL.
REQ-007 EVAL SHALL test the current player's board against the 8 lines: {0,1,2}, {3,4,5}, {6,7,8}, {0,3,6}, {1,4,7}, {2,5,8}, {0,4,8}, {2,4,6}.
REQ-008 EVAL, line complete: winner SHALL become 01 (X) or 10 (O) and the FSM SHALL go to OVER.
REQ-009 EVAL, no line and mv_cnt=9: winner SHALL become 11 and the FSM SHALL go to OVER.
REQ-010 EVAL, no line and mv_cnt<9: turn SHALL toggle and the FSM SHALL return to PLAY.
REQ-011 Win takes priority over draw when the 9th move completes a line.
REQ-012 A move_valid arriving in CHECK or EVAL SHALL be ignored, with no ack and no err.
REQ-013 A move_valid arriving in OVER SHALL produce a move_err pulse on the next cycle.
REQ-014 game_over SHALL equal (state==OVER), registered.
REQ-015 new_game=1 in any state SHALL, on the next cycle, clear brd_x, brd_o, mv_cnt and winner, set turn=0, and set state=PLAY.
REQ-016 new_game SHALL take priority over a simultaneous move_valid, and that move SHALL be discarded.
REQ-017 new_game SHALL suppress any ack or err pulse due in the same cycle.
REQ-018 Move latency SHALL be: move_valid at cycle N gives move_ack or move_err at N+2, and winner/turn updated at N+3.
REQ-019 The module SHALL accept back-to-back moves one every 3 cycles or slower.
REQ-020 Display buffer: sq_x/sq_o SHALL load from brd_x/brd_o only on the cycle after a rising edge of vblnk_in (vblnk_in=1 with the registered previous value 0), and SHALL hold otherwise.
REQ-021 A board change, including new_game, SHALL therefore become visible on the first vblank edge after it.
REQ-022 If a board write and a vblank edge land on the same cycle, the buffer SHALL load the pre-write board; the new mark appears at the next frame.
REQ-023 All outputs SHALL be registered.
REQ-024 move_ack and move_err SHALL never be high together.

Reset
REQ-025 With rst=1 at a pclk edge, the next cycle SHALL give: state=PLAY, brd_x=brd_o=sq_x=sq_o=0, mv_cnt=0, turn=0, winner=00, game_over=0, move_ack=move_err=0, and vblnk edge register=0.
REQ-026 rst SHALL override new_game and move_valid.
REQ-027 rst asserted mid-move (in CHECK or EVAL) SHALL abort that move with no ack and no err.

Verification
REQ-028 After reset, move_idx=4 with move_valid: move_ack at N+2, turn=1 at N+3; after the next vblank rising edge, sq_x=9'h010 and sq_o=0.
REQ-029 Square 4 occupied, then move_idx=4: move_err at N+2, board unchanged, turn unchanged. A separate move_idx=12: move_err.
REQ-030 X plays 0,1,2 with O playing 3,4: winner=01 and game_over=1 at 3 cycles after the 5th move; a further move gives move_err.
REQ-031 Full-board sequence X:0,2,3,7,8 / O:1,4,5,6 with no line: winner=11 after the 9th move.
REQ-032 Board update while vblnk_in is held high: sq_x/sq_o unchanged until vblnk_in falls and rises again.
REQ-033 new_game coincident with move_valid mid-game: next cycle board=0, turn=0, no ack; displayed sq_x/sq_o clear only after the next vblank edge.
